// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the cascaded up/down counter sequencer:
// controller state encoding, reset defaults and prescaler width.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int TC_DEFAULT       = 12;
    localparam int DN_DEFAULT       = 15;
    localparam int PRESCALE_W       = 8;
    localparam int PRESCALE_DEFAULT = 4;

    // RUN and PAUSE both count as an epoch in progress.
    function automatic logic state_is_busy(input state_e st);
        return (st == ST_RUN) || (st == ST_PAUSE);
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_prescaler.sv
// Advance-tick generator for counter_seq_ctrl. Only built when the
// COUNTER_PRESCALE_EN macro is defined; otherwise the file is empty and the
// controller advances on every RUN clock.
`ifdef COUNTER_PRESCALE_EN
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST_CNT = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] ZERO_CNT = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] ONE_CNT  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    // Terminal tick: last clock of each PRESCALE-long window while running.
    assign tick = run && !clr && (cnt_q == LAST_CNT);

    // Count only in RUN; any other state or a clear parks the counter at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || clr) begin
            cnt_d = ZERO_CNT;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = ZERO_CNT;
        end else begin
            cnt_d = cnt_q + ONE_CNT;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= ZERO_CNT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a cascaded up/down counter pair. The up counter
// runs 0..tc_reg; each wrap pulses carry and decrements the down counter, and
// the epoch ends in DONE when the down counter reaches zero.
// Optional feature: define COUNTER_PRESCALE_EN to advance only once every
// PRESCALE clocks (tick from counter_prescaler).
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int TC_DEFAULT = counter_pkg::TC_DEFAULT,
    parameter int DN_DEFAULT = counter_pkg::DN_DEFAULT,
    parameter int PRESCALE   = counter_pkg::PRESCALE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] tc_value,
    input  logic [WIDTH-1:0] dn_init,
    output logic [WIDTH-1:0] up,
    output logic [WIDTH-1:0] dn,
    output logic             carry,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TC_RST = WIDTH'(TC_DEFAULT);
    localparam logic [WIDTH-1:0] DN_RST = WIDTH'(DN_DEFAULT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] up_q, up_d;
    logic [WIDTH-1:0] dn_q, dn_d;
    logic [WIDTH-1:0] tc_reg_q, tc_reg_d;
    logic [WIDTH-1:0] dn_reg_q, dn_reg_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;

    logic adv_s;
    logic go_s;
    logic cfg_window_s;
    logic cfg_ok_s;

`ifdef COUNTER_PRESCALE_EN
    logic run_s;
    logic tick_s;

    assign run_s = (state_q == ST_RUN);

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run_s),
        .clr  (clear),
        .tick (tick_s)
    );

    assign adv_s = tick_s;
`else
    assign adv_s = 1'b1;
`endif

    // stop outranks start, so start only counts when stop is low.
    assign go_s = start && !stop;

    // A clear in the same cycle puts the load into IDLE context.
    assign cfg_window_s = clear || (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign cfg_ok_s     = cfg_load && (dn_init != ZERO_W) && cfg_window_s;

    // Next-state, counter and configuration update; clear beats all commands.
    always_comb begin
        state_d   = state_q;
        up_d      = up_q;
        dn_d      = dn_q;
        tc_reg_d  = tc_reg_q;
        dn_reg_d  = dn_reg_q;
        carry_d   = 1'b0;
        cfg_err_d = 1'b0;

        if (cfg_ok_s) begin
            tc_reg_d = tc_value;
            dn_reg_d = dn_init;
        end else begin
            cfg_err_d = cfg_load;
        end

        if (clear) begin
            state_d = ST_IDLE;
            up_d    = ZERO_W;
            dn_d    = dn_reg_d;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_ok_s) begin
                        dn_d = dn_init;
                    end else begin
                        dn_d = dn_q;
                    end
                    if (go_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (adv_s) begin
                        // >= also recovers an out-of-range up value with a wrap.
                        if (up_q >= tc_reg_q) begin
                            up_d    = ZERO_W;
                            carry_d = 1'b1;
                            dn_d    = dn_q - ONE_W;
                            if (dn_q == ONE_W) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            up_d = up_q + ONE_W;
                        end
                    end else begin
                        up_d = up_q;
                    end
                end
                ST_PAUSE: begin
                    if (go_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (go_s) begin
                        state_d = ST_RUN;
                        up_d    = ZERO_W;
                        dn_d    = dn_reg_d;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    up_d    = ZERO_W;
                    dn_d    = dn_reg_q;
                end
            endcase
        end

        busy_d = state_is_busy(state_d);
        done_d = (state_d == ST_DONE);
    end

    // State, counters, configuration and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            up_q      <= ZERO_W;
            dn_q      <= DN_RST;
            tc_reg_q  <= TC_RST;
            dn_reg_q  <= DN_RST;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            tc_reg_q  <= tc_reg_d;
            dn_reg_q  <= dn_reg_d;
            carry_q   <= carry_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign up      = up_q;
    assign dn      = dn_q;
    assign carry   = carry_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl (default build, no prescaler).
// The driver advances a behavioural model one clock per command and queues
// the expected outputs; a monitor pops and compares after each rising edge.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, cfg_load = 1'b0;
    logic [3:0] tc_value = 4'd0, dn_init = 4'd0;
    logic [3:0] up, dn;
    logic       carry, busy, done, cfg_err;
    logic [1:0] state;

    typedef struct {
        logic [3:0] up;
        logic [3:0] dn;
        logic       carry;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // model: mode 0 idle, 1 run, 2 pause, 3 done
    int m_st, m_up, m_dn, m_tc, m_dr;

    counter_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .cfg_load (cfg_load),
        .tc_value (tc_value),
        .dn_init  (dn_init),
        .up       (up),
        .dn       (dn),
        .carry    (carry),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_up = 0; m_dn = 15; m_tc = 12; m_dr = 15;
    endtask

    // Called at a falling edge: drive, predict, then wait out one clock.
    task automatic cycle(input bit s, input bit p, input bit c, input bit ld,
                         input int tcv, input int dni);
        exp_t e;
        bit   ok;
        start = s; stop = p; clear = c; cfg_load = ld;
        tc_value = tcv[3:0]; dn_init = dni[3:0];
        e.carry = 1'b0;
        ok = ld && (dni != 0) && (c || m_st == 0 || m_st == 3);
        e.err = ld && !ok;
        if (ok) begin m_tc = tcv; m_dr = dni; end
        if (c) begin
            m_st = 0; m_up = 0; m_dn = m_dr;
        end else begin
            case (m_st)
                0: begin
                    if (ok) m_dn = dni;
                    if (s && !p) m_st = 1;
                end
                1: begin
                    if (p) m_st = 2;
                    else if (m_up >= m_tc) begin
                        m_up = 0;
                        e.carry = 1'b1;
                        if (m_dn == 1) m_st = 3;
                        m_dn = (m_dn + 15) % 16;
                    end else m_up = m_up + 1;
                end
                2: if (s && !p) m_st = 1;
                3: if (s && !p) begin m_st = 1; m_up = 0; m_dn = m_dr; end
                default: m_st = 0;
            endcase
        end
        e.up = m_up[3:0];
        e.dn = m_dn[3:0];
        e.busy = (m_st == 1) || (m_st == 2);
        e.done = (m_st == 3);
        e.st = m_st[1:0];
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Run idle clocks until done rises; n is the number of clocks spent.
    task automatic run_to_done(input int max, output int n);
        n = 0;
        do begin
            idle_cycle();
            n++;
        end while (!done && n < max);
        chk("done_timeout", int'(done), 1);
    endtask

    // Monitor: compare the queued expectation just after each rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (up !== e.up || dn !== e.dn || carry !== e.carry || busy !== e.busy ||
                    done !== e.done || cfg_err !== e.err || state !== e.st) begin
                    n_bad++;
                    $display("FAIL scoreboard @%0t: got st=%0d up=%0d dn=%0d carry=%0b busy=%0b done=%0b cfg_err=%0b; expected st=%0d up=%0d dn=%0d carry=%0b busy=%0b done=%0b cfg_err=%0b",
                             $time, state, up, dn, carry, busy, done, cfg_err,
                             e.st, e.up, e.dn, e.carry, e.busy, e.done, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int n, a, g;
        model_reset();
        #12;
        chk("reset_state", int'(state), 0);
        chk("reset_up", int'(up), 0);
        chk("reset_dn", int'(dn), 15);
        chk("reset_flags", int'({carry, busy, done, cfg_err}), 0);
        @(negedge clk);
        rst = 1'b1;

        // Defaults: (12+1)*15 advances from RUN entry to done.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_to_done(400, n);
        chk("latency_default", n, 13 * 15);
        idle_cycle();

        // Load tc=3, dn=2 in IDLE after a clear.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 3, 2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_to_done(50, n);
        chk("latency_tc3_dn2", n, 8);

        // Pause at up=3 with tc=5, dn=3, then resume.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 5, 3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        a = 0;
        while (up != 4'd3 && a < 20) begin idle_cycle(); a++; end
        chk("reach_up3", int'(up), 3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) idle_cycle();
        chk("paused_up_hold", int'(up), 3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);   // stop beats start
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_to_done(50, n);
        chk("pause_total_advances", a + n, 6 * 3);

        // Rejected loads: during RUN, during PAUSE, and dn_init=0 in IDLE.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 9, 9);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 7, 0);
        chk("rejected_keeps_dn", int'(dn), 3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_to_done(50, n);
        chk("latency_after_rejects", n, 6 * 3);

        // Clear on the very edge of a wrap: IDLE, up=0, dn=dn_reg, no carry.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 3, 5);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        g = 0;
        while (up != 4'd3 && g < 20) begin idle_cycle(); g++; end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("clear_wrap_carry", int'(carry), 0);
        chk("clear_wrap_dn", int'(dn), 5);

        // Asynchronous reset mid-RUN at dn=7, up=9.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 12, 15);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        g = 0;
        while (!(dn == 4'd7 && up == 4'd9) && g < 300) begin idle_cycle(); g++; end
        chk("reach_dn7_up9", int'({dn, up}), int'({4'd7, 4'd9}));
        start = 1'b0; stop = 1'b0; clear = 1'b0; cfg_load = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_counts", int'({up, dn}), int'({4'd0, 4'd15}));
        chk("async_rst_flags", int'({carry, busy, done, cfg_err}), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomised commands and configuration.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        idle_cycle();
        idle_cycle();
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencing controller for the cascaded up/down counter pair. Holds the terminal-count and epoch configuration and runs the pair under start/stop/clear commands. The low counter counts up to a programmable terminal count. Each wrap raises a single-cycle carry that decrements the high counter. All logic is synchronous to one clock, with no derived clocks. Sits between the control/config bus and the counter datapath and reports busy/done to the system.

Parameters:
WIDTH, 4, width of up, dn, tc_value, dn_init.
TC_DEFAULT, 12, terminal count of the up counter after reset.
DN_DEFAULT, 15, initial value of the down counter after reset and after clear.
PRESCALE, 4, clocks per count advance; used only when COUNTER_PRESCALE_EN is defined; legal range 2..255.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  level command: enter RUN from IDLE/PAUSE.
stop  input  1  level command: enter PAUSE from RUN.
clear  input  1  level command: return to IDLE and reload the counters.
cfg_load  input  1  single-cycle strobe that loads tc_value and dn_init.
tc_value  input  WIDTH  new terminal count for the up counter.
dn_init  input  WIDTH  new epoch count for the down counter.
up  output  WIDTH  low (up) counter value.
dn  output  WIDTH  high (down) counter value.
carry  output  1  one-cycle pulse coinciding with the up wrap.
busy  output  1  high in RUN and PAUSE.
done  output  1  high in DONE.
cfg_err  output  1  one-cycle pulse when cfg_load is rejected.
state  output  2  current state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (rst low, asynchronous) sets the following, all registered:
  - state=IDLE, up=0, dn=DN_DEFAULT, tc_reg=TC_DEFAULT, dn_reg=DN_DEFAULT.
  - carry=0, busy=0, done=0, cfg_err=0.
- Command priority within a cycle: clear > stop > start.
- IDLE:
  - up and dn hold.
  - start goes to RUN on the next edge; the first increment happens on the edge after entering RUN.
- RUN, advance every cycle:
  - If up != tc_reg: up <= up+1.
  - If up == tc_reg: up <= 0, carry <= 1, dn <= dn-1, all on the same edge.
  - If dn==1 at that wrap: dn <= 0, state <= DONE, done <= 1 on the same edge.
  - Start-to-done latency is (tc_reg+1)*dn_reg advances.
- PAUSE:
  - up and dn hold; carry=0.
  - start returns to RUN and resumes from the held values, with no lost or duplicated count.
  - stop and start both high in the same cycle counts as stop.
- DONE:
  - up=0 and dn=0 hold; done stays high.
  - start reloads up=0 and dn=dn_reg and goes to RUN.
- clear (any state): next edge gives state=IDLE, up=0, dn=dn_reg, carry=0, done=0.
- carry is 0 in every cycle except the wrap cycle. tc_reg=0 gives carry on every advance.
- cfg_load acceptance:
  - Accepted only in IDLE or DONE: tc_reg <= tc_value, dn_reg <= dn_init.
  - In IDLE, dn is also updated to dn_init immediately.
- cfg_load rejection:
  - Rejected in RUN or PAUSE, or when dn_init==0.
  - On rejection cfg_err pulses one cycle and the configuration is unchanged.
- cfg_load and clear in the same cycle: clear executes first, then the load applies. The resulting dn is dn_init when accepted.
- up never exceeds tc_reg. All arithmetic is WIDTH-bit modulo.
- If tc_reg < up, a state not reachable through legal loads, the next advance wraps to 0 with carry.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined: an 8-bit prescaler runs only in RUN and is cleared on entry to RUN, on PAUSE, and on clear. The counter advances only on the prescaler's terminal tick, once every PRESCALE clocks, so latency is multiplied by PRESCALE. carry still lasts one clock.
- Undefined: no prescaler logic; the counter advances every RUN clock; the PRESCALE parameter is ignored.

Decomposition:
- Shared package counter_pkg holds:
  - The state enum (IDLE/RUN/PAUSE/DONE, 2-bit).
  - Constants TC_DEFAULT, DN_DEFAULT, PRESCALE_W=8.
- Sub-module counter_prescaler holds the tick generator and is instantiated only under COUNTER_PRESCALE_EN.
- The FSM, the counters and the config registers stay in the top block.

Test Plan:
- Reset then start with defaults (tc=12, dn=15) -> carry every 13 cycles, dn 15->14->...->0, done after 195 cycles, busy low at done.
- In IDLE, cfg_load tc=3, dn_init=2, then start -> carry at cycles 4 and 8, done asserted at cycle 8, up=0, dn=0.
- Run with tc=5, stop at up=3, hold 10 cycles, start -> up resumes 4,5,0 with carry on the wrap; total cycles in RUN equal the unpaused reference.
- cfg_load during RUN, and cfg_load with dn_init=0 in IDLE -> cfg_err one-cycle pulse each time; tc/dn unchanged.
- Assert rst low mid-RUN at dn=7, up=9 -> all outputs reset immediately, without waiting for a clock. Also assert clear in the same cycle as the wrap -> IDLE, up=0, dn=dn_reg, no carry.
- With COUNTER_PRESCALE_EN defined and PRESCALE=4, tc=2, dn_init=1 -> up changes every 4 clocks, carry is a one-clock pulse, done after 12 clocks.
